// File: rtl/mem_arbiter_if.sv
// Request/response and memory-port bundle for mem_arbiter.
// Optional stats outputs exist only with MEM_ARBITER_STATS_EN.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_r_w;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_in;
    logic [DW-1:0] mem_out;
`ifdef MEM_ARBITER_STATS_EN
    logic [15:0]   stat_if_gnt;
    logic [15:0]   stat_d_gnt;
    logic [15:0]   stat_conflict;
`endif

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_out,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_r_w, mem_address, mem_in
`ifdef MEM_ARBITER_STATS_EN
        , output stat_if_gnt, stat_d_gnt, stat_conflict
`endif
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_out,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_r_w, mem_address, mem_in
`ifdef MEM_ARBITER_STATS_EN
        , input stat_if_gnt, stat_d_gnt, stat_conflict
`endif
    );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for the unified single-port memory, 2-cycle read return.
// Define MEM_ARBITER_STATS_EN to add saturating grant/conflict counters.
module mem_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MAX_D_BURST = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_arbiter_if.slave   bus
);
    localparam logic [3:0] MAXB = 4'(MAX_D_BURST);

    logic [3:0] burst_cnt;
    logic       burst_full;
    logic       d_gnt;
    logic       if_gnt;
    logic       rd_gnt;
    logic [1:0] tag_vld;
    logic [1:0] tag_own;

    assign burst_full = (burst_cnt >= MAXB);
    assign d_gnt  = rst_n & bus.d_req & (~bus.if_req | ~burst_full);
    assign if_gnt = rst_n & bus.if_req & ~d_gnt;
    assign rd_gnt = if_gnt | (d_gnt & ~bus.d_we);

    assign bus.d_gnt  = d_gnt;
    assign bus.if_gnt = if_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt <= '0;
        end else if (!bus.if_req || if_gnt) begin
            burst_cnt <= '0;
        end else if (d_gnt && !burst_full) begin
            burst_cnt <= burst_cnt + 4'd1;
        end
    end

    // Issue stage: address/data hold when nothing is granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mem_en      <= 1'b0;
            bus.mem_r_w     <= 1'b0;
            bus.mem_address <= '0;
            bus.mem_in      <= '0;
        end else begin
            bus.mem_en <= d_gnt | if_gnt;
            if (d_gnt) begin
                bus.mem_r_w     <= bus.d_we;
                bus.mem_address <= bus.d_addr;
                bus.mem_in      <= bus.d_wdata;
            end else if (if_gnt) begin
                bus.mem_r_w     <= 1'b0;
                bus.mem_address <= bus.if_addr;
            end
        end
    end

    // Tag pipe: owner 1 = data port, 0 = fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld <= '0;
            tag_own <= '0;
        end else begin
            tag_vld <= {tag_vld[0], rd_gnt};
            tag_own <= {tag_own[0], d_gnt};
        end
    end

    assign bus.if_rvalid = tag_vld[1] & ~tag_own[1];
    assign bus.d_rvalid  = tag_vld[1] & tag_own[1];
    assign bus.if_rdata  = bus.if_rvalid ? bus.mem_out : '0;
    assign bus.d_rdata   = bus.d_rvalid ? bus.mem_out : '0;

`ifdef MEM_ARBITER_STATS_EN
    logic [15:0] st_if;
    logic [15:0] st_d;
    logic [15:0] st_cf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_if <= '0;
            st_d  <= '0;
            st_cf <= '0;
        end else begin
            if (if_gnt && st_if != 16'hFFFF)
                st_if <= st_if + 16'd1;
            if (d_gnt && st_d != 16'hFFFF)
                st_d <= st_d + 16'd1;
            if (bus.if_req && bus.d_req && st_cf != 16'hFFFF)
                st_cf <= st_cf + 16'd1;
        end
    end

    assign bus.stat_if_gnt   = st_if;
    assign bus.stat_d_gnt    = st_d;
    assign bus.stat_conflict = st_cf;
`endif
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port unified memory (imem + dmem, word-addressed, 1-cycle registered read, en/r_w control).
- Shares the port between instruction fetch (read-only) and the load/store unit (read/write).
- Data requests have priority, with a bounded-burst fairness rule so fetch cannot starve.
- Memory-side outputs are registered; read data returns with a fixed 2-cycle latency from grant.

Parameters:
- AW, 32, address width (word index passed straight to memory).
- DW, 32, data width.
- MAX_D_BURST, 4, max consecutive data grants while fetch is pending (legal 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  AW  fetch word address.
- if_gnt  out  1  fetch accepted this cycle (combinational).
- if_rvalid  out  1  fetch read data valid (1-cycle pulse).
- if_rdata  out  DW  fetch read data.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  AW  data word address.
- d_wdata  in  DW  write data.
- d_gnt  out  1  data accepted this cycle (combinational).
- d_rvalid  out  1  data read valid (1-cycle pulse, reads only).
- d_rdata  out  DW  data read data.
- mem_en  out  1  memory enable (registered).
- mem_r_w  out  1  memory 0 = read, 1 = write (registered).
- mem_address  out  AW  memory address (registered).
- mem_in  out  DW  memory write data (registered).
- mem_out  in  DW  memory read data.

Behaviour:
- Reset: all outputs 0; burst counter 0; return pipeline cleared. Async assert, sync-safe deassert handled upstream.
- At most one grant per cycle; grant is a one-cycle pulse in the cycle the request is accepted. Requesters hold addr/data stable until granted.
- Arbitration in cycle N:
  - only d_req -> d_gnt.
  - only if_req -> if_gnt.
  - both and burst_cnt < MAX_D_BURST -> d_gnt, burst_cnt++.
  - both and burst_cnt == MAX_D_BURST -> if_gnt.
- burst_cnt clears on any if_gnt or on any cycle with if_req = 0. It saturates at MAX_D_BURST.
- Issue stage: at the edge ending grant cycle N, mem_en/mem_r_w/mem_address/mem_in load the granted request. With no grant, mem_en = 0 and the other mem_* hold their previous values.
- Return stage: a 2-deep tag pipe ({valid, owner}) tracks reads only. Writes never produce rvalid.
  - For a read granted in N, the memory samples in N+1 and mem_out is valid in N+2.
  - In N+2, the owner's rvalid = 1 and its rdata = mem_out.
- rdata ports are muxed from mem_out: the non-owner's rdata is 0, and both are 0 when no return is due.
- Back-to-back grants are legal every cycle, giving full throughput with no bubbles. Mixed write-then-read to the same address returns the new data (memory order = grant order).
- Reset mid-operation discards in-flight reads: no rvalid after rst_n releases until a new read is granted.
- Simultaneous grant and return in the same cycle are independent.

Optional Feature:
- Macro: MEM_ARBITER_STATS_EN.
- Defined: adds outputs stat_if_gnt[15:0], stat_d_gnt[15:0] and stat_conflict[15:0].
  - stat_if_gnt and stat_d_gnt count grants.
  - stat_conflict counts cycles with if_req and d_req both high.
  - All three saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Single fetch: if_req = 1, if_addr = 0x10 (mem[0x10] = 0xDEADBEEF) -> if_gnt at N; mem_en = 1, mem_r_w = 0, mem_address = 0x10 at N+1; if_rvalid = 1, if_rdata = 0xDEADBEEF at N+2.
- Data write then read: write 0x800 <- 0x12345678, then read 0x800 next cycle -> d_gnt both cycles, no d_rvalid for the write, d_rvalid with 0x12345678 exactly 2 cycles after the read grant.
- Contention fairness: if_req and d_req held high for 12 cycles, MAX_D_BURST = 4 -> grant pattern D,D,D,D,I repeating; fetch is never starved beyond 4 cycles.
- Back-to-back fetch: 8 consecutive fetches of addrs 0..7 -> 8 consecutive if_gnt and 8 consecutive if_rvalid with matching data, no bubbles.
- Reset mid-read: read granted at N, rst_n low at N+1 for 2 cycles -> all outputs 0, no rvalid after release, burst_cnt = 0.
- Stats (macro defined): 5 conflict cycles plus 3 solo fetches -> stat_conflict = 5, stat_if_gnt = 4, stat_d_gnt = 4 (MAX_D_BURST = 4).
